// File: rtl/toggle_cov_pkg.sv
// Shared definitions for the toggle coverage detector.
// Contents:
//   RISE / FALL : bit offsets of the rise and fall points within a 2-bit per-signal group.
//   cnt_width() : width needed to hold a covered-point count of 0..2*sig_width.
package toggle_cov_pkg;

  localparam int unsigned RISE = 0;
  localparam int unsigned FALL = 1;

  function automatic int unsigned cnt_width(input int unsigned sig_width);
    return $clog2(2 * sig_width + 1);
  endfunction

endpackage

// File: rtl/toggle_cov_cell.sv
// Per-signal-bit toggle detector.
// Ports:
//   i_clock, i_reset_n : clock and asynchronous active-low reset
//   i_sig              : monitored signal bit
//   i_prev_valid       : high once a previous sample exists (shared from the top)
//   i_enable, i_clear  : detection enable and coverage clear
//   o_valid[1:0]       : registered rise/fall event pulses
//   o_covered[1:0]     : sticky rise/fall coverage bits
//   o_covered_d[1:0]   : next-state coverage bits, used by the top for its popcount
module toggle_cov_cell
  import toggle_cov_pkg::*;
#(
  parameter bit FIRST_ONLY = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_sig,
  input  logic       i_prev_valid,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic [1:0] o_valid,
  output logic [1:0] o_covered,
  output logic [1:0] o_covered_d
);

  logic       r_prev;
  logic [1:0] r_valid;
  logic [1:0] r_covered;

  logic       w_arm;
  logic [1:0] w_raw;
  logic [1:0] w_valid_d;
  logic [1:0] w_covered_d;

  always_comb begin
    // Clear wins over a simultaneous toggle; no edges before the first real sample.
    w_arm       = i_prev_valid & i_enable & ~i_clear;
    w_raw       = '0;
    w_raw[RISE] = w_arm & i_sig & ~r_prev;
    w_raw[FALL] = w_arm & ~i_sig & r_prev;
    w_valid_d   = FIRST_ONLY ? (w_raw & ~r_covered) : w_raw;
    w_covered_d = i_clear ? 2'b00 : (r_covered | w_raw);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev    <= 1'b0;
      r_valid   <= 2'b00;
      r_covered <= 2'b00;
    end else begin
      // prev tracks the input unconditionally so re-enabling never sees a stale sample.
      r_prev    <= i_sig;
      r_valid   <= w_valid_d;
      r_covered <= w_covered_d;
    end
  end

  assign o_valid     = r_valid;
  assign o_covered   = r_covered;
  assign o_covered_d = w_covered_d;

endmodule

// File: rtl/toggle_cov_detect.sv
// Toggle coverage detector: flags first (or every) rise/fall of each monitored bit.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   sig            : monitored signals, sampled every clock
//   enable         : detection enable
//   clear          : one-cycle clear of coverage bitmap and count
//   valid          : event pulses, bit 2i = rise of sig[i], bit 2i+1 = fall of sig[i]
//   covered        : sticky bitmap of points hit
//   covered_count  : population count of covered
//   all_covered    : every point has been hit
module toggle_cov_detect
  import toggle_cov_pkg::*;
#(
  parameter int unsigned SIG_WIDTH  = 18,
  parameter bit          FIRST_ONLY = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [SIG_WIDTH-1:0]              sig,
  input  logic                              enable,
  input  logic                              clear,
  output logic [2*SIG_WIDTH-1:0]            valid,
  output logic [2*SIG_WIDTH-1:0]            covered,
  output logic [cnt_width(SIG_WIDTH)-1:0]   covered_count,
  output logic                              all_covered
);

  localparam int unsigned CntW   = cnt_width(SIG_WIDTH);
  localparam int unsigned Points = 2 * SIG_WIDTH;

  logic                  r_prev_valid;
  logic [CntW-1:0]       r_count;
  logic [Points-1:0]     w_covered_d;
  logic [CntW-1:0]       w_count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_valid <= 1'b1;
    end
  end

  for (genvar i = 0; i < SIG_WIDTH; i++) begin : g_cell
    toggle_cov_cell #(
      .FIRST_ONLY (FIRST_ONLY)
    ) u_cell (
      .i_clock      (clock),
      .i_reset_n    (reset_n),
      .i_sig        (sig[i]),
      .i_prev_valid (r_prev_valid),
      .i_enable     (enable),
      .i_clear      (clear),
      .o_valid      (valid[2*i+1:2*i]),
      .o_covered    (covered[2*i+1:2*i]),
      .o_covered_d  (w_covered_d[2*i+1:2*i])
    );
  end

  // Count is taken from next-state coverage so it registers in step with covered.
  always_comb begin
    w_count_d = '0;
    for (int unsigned i = 0; i < Points; i++) begin
      w_count_d = w_count_d + CntW'(w_covered_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign covered_count = r_count;
  assign all_covered   = (r_count == CntW'(Points));

endmodule

// File: tb/tb_toggle_cov_detect.sv
module tb_toggle_cov_detect;

  logic        clock;
  logic        reset_n;
  logic [17:0] sig;
  logic        enable;
  logic        clear;
  logic [35:0] valid;
  logic [35:0] covered;
  logic [5:0]  covered_count;
  logic        all_covered;

  toggle_cov_detect #(
    .SIG_WIDTH  (18),
    .FIRST_ONLY (1'b1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sig           (sig),
    .enable        (enable),
    .clear         (clear),
    .valid         (valid),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [35:0] valid;
    logic [35:0] cov;
    int          cnt;
    logic        all;
  } exp_t;

  typedef struct {
    logic [17:0] sig;
    logic        en;
    logic        clr;
    logic [35:0] valid;
    logic [35:0] cov;
    int          cnt;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [17:0] m_prev;
  logic        m_pv;
  logic [35:0] m_cov;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [17:0] s, input logic en, input logic clr,
                            output exp_t e);
    logic [35:0] raw;
    raw = '0;
    if (m_pv && en && !clr) begin
      for (int i = 0; i < 18; i++) begin
        raw[2*i]   = s[i] & ~m_prev[i];
        raw[2*i+1] = ~s[i] & m_prev[i];
      end
    end
    e.valid = raw & ~m_cov;
    m_cov   = clr ? 36'h0 : (m_cov | raw);
    e.cov   = m_cov;
    e.cnt   = $countones(m_cov);
    e.all   = (e.cnt == 36);
    m_prev  = s;
    m_pv    = 1'b1;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input string name, input logic [17:0] s, input logic en,
                       input logic clr, input exp_t e);
    exp_t got;
    sig    = s;
    enable = en;
    clear  = clr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", name);
    end else begin
      got = sb.pop_front();
      chk({name, ".valid"}, valid, got.valid);
      chk({name, ".covered"}, covered, got.cov);
      chk({name, ".count"}, {30'b0, covered_count}, 36'(got.cnt));
      chk({name, ".all"}, {35'b0, all_covered}, {35'b0, got.all});
    end
  endtask

  task automatic model_apply(input string name, input logic [17:0] s, input logic en,
                             input logic clr);
    exp_t e;
    model_step(s, en, clr, e);
    apply(name, s, en, clr, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // sig, en, clr, expected valid, expected covered, expected count
    tbl[0]  = '{18'h3FFFF, 1'b1, 1'b0, 36'h0,   36'h0,   0}; // first sample suppressed
    tbl[1]  = '{18'h3FFFF, 1'b1, 1'b0, 36'h0,   36'h0,   0};
    tbl[2]  = '{18'h00000, 1'b1, 1'b1, 36'h0,   36'h0,   0}; // all fall, clear wins
    tbl[3]  = '{18'h00000, 1'b1, 1'b0, 36'h0,   36'h0,   0};
    tbl[4]  = '{18'h00001, 1'b1, 1'b0, 36'h1,   36'h1,   1}; // sig[0] rise
    tbl[5]  = '{18'h00001, 1'b1, 1'b0, 36'h0,   36'h1,   1}; // one-cycle pulse
    tbl[6]  = '{18'h00000, 1'b1, 1'b0, 36'h2,   36'h3,   2}; // sig[0] fall
    tbl[7]  = '{18'h00001, 1'b1, 1'b0, 36'h0,   36'h3,   2}; // already covered
    tbl[8]  = '{18'h00000, 1'b1, 1'b0, 36'h0,   36'h3,   2};
    tbl[9]  = '{18'h00000, 1'b1, 1'b1, 36'h0,   36'h0,   0}; // clear
    tbl[10] = '{18'h00020, 1'b1, 1'b1, 36'h0,   36'h0,   0}; // sig[5] rise during clear
    tbl[11] = '{18'h00020, 1'b1, 1'b0, 36'h0,   36'h0,   0};
    tbl[12] = '{18'h00000, 1'b1, 1'b0, 36'h800, 36'h800, 1}; // sig[5] fall
    tbl[13] = '{18'h00020, 1'b1, 1'b0, 36'h400, 36'hC00, 2}; // sig[5] rise -> bit10

    reset_n = 1'b0;
    sig     = 18'h3FFFF;
    enable  = 1'b1;
    clear   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.valid", valid, 36'h0);
    chk("reset.covered", covered, 36'h0);
    chk("reset.count", {30'b0, covered_count}, 36'h0);
    chk("reset.all", {35'b0, all_covered}, 36'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      e.valid = tbl[i].valid;
      e.cov   = tbl[i].cov;
      e.cnt   = tbl[i].cnt;
      e.all   = (tbl[i].cnt == 36);
      apply($sformatf("vec%0d", i), tbl[i].sig, tbl[i].en, tbl[i].clr, e);
    end

    m_prev = tbl[13].sig;
    m_pv   = 1'b1;
    m_cov  = tbl[13].cov;

    // Full coverage: clear, every bit rises, then every bit falls.
    model_apply("full.clr", 18'h00000, 1'b1, 1'b1);
    model_apply("full.rise", 18'h3FFFF, 1'b1, 1'b0);
    model_apply("full.fall", 18'h00000, 1'b1, 1'b0);
    chk("full.all_hi", {35'b0, all_covered}, 36'h1);
    model_apply("full.hold", 18'h00000, 1'b1, 1'b0);

    // Disabled toggling of sig[3], then re-enable with sig steady.
    model_apply("dis.clr", 18'h00000, 1'b1, 1'b1);
    model_apply("dis.t0", 18'h00008, 1'b0, 1'b0);
    model_apply("dis.t1", 18'h00000, 1'b0, 1'b0);
    model_apply("dis.t2", 18'h00008, 1'b0, 1'b0);
    model_apply("dis.en0", 18'h00008, 1'b1, 1'b0);
    model_apply("dis.en1", 18'h00008, 1'b1, 1'b0);
    chk("dis.cov_zero", covered, 36'h0);

    // Random traffic with occasional clears and disables.
    for (int i = 0; i < 150; i++) begin
      model_apply($sformatf("rnd%0d", i), 18'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    // Reset mid-operation between edges: outputs drop immediately.
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.valid", valid, 36'h0);
    chk("midrst.covered", covered, 36'h0);
    chk("midrst.count", {30'b0, covered_count}, 36'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    m_prev  = '0;
    m_pv    = 1'b0;
    m_cov   = '0;
    model_apply("post.first", 18'h2AAAA, 1'b1, 1'b0);
    model_apply("post.hold", 18'h2AAAA, 1'b1, 1'b0);
    model_apply("post.tog", 18'h15555, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_cov_detect.md
TOGGLE_COV_DETECT -- requirements
Module: toggle_cov_detect

Interface
REQ-001 The block SHALL have parameter SIG_WIDTH, default 18: number of monitored signal bits.
REQ-002 The block SHALL have parameter FIRST_ONLY, default 1: 1 = report each toggle point once until cleared; 0 = report every toggle.
REQ-003 The block SHALL have port clock, input, 1: sole clock, all state on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port sig, input, SIG_WIDTH: monitored signals, sampled every clock.
REQ-006 The block SHALL have port enable, input, 1: detection enabled when 1.
REQ-007 The block SHALL have port clear, input, 1: single-cycle command to clear the covered bitmap and count.
REQ-008 The block SHALL have port valid, output, 2*SIG_WIDTH: toggle event pulses for the downstream coverage reporter.
REQ-009 The block SHALL have port covered, output, 2*SIG_WIDTH: sticky bitmap of points already hit.
REQ-010 The block SHALL have port covered_count, output, clog2(2*SIG_WIDTH+1): population count of covered.
REQ-011 The block SHALL have port all_covered, output, 1: high when covered_count equals 2*SIG_WIDTH.

Function
REQ-012 Bit 2i of valid SHALL flag a rise (0->1) of sig[i]; bit 2i+1 SHALL flag a fall (1->0).
REQ-013 A registered previous-sample copy prev SHALL update from sig every cycle, regardless of enable or clear.
REQ-014 A prev_valid flag SHALL clear on reset and set on the first clock after reset; no edge SHALL be detected while prev_valid is 0.
REQ-015 Raw edge SHALL equal (prev_valid & enable & ~clear) AND rise/fall of sig versus prev.
REQ-016 valid SHALL be registered: a toggle of sig sampled at edge N SHALL appear on valid during cycle N+1, for exactly one cycle.
REQ-017 With FIRST_ONLY=1, valid SHALL assert only for raw edges whose covered bit is 0; with FIRST_ONLY=0, valid SHALL equal the raw edge vector.
REQ-018 covered SHALL OR in raw edges each cycle and SHALL update in the same cycle valid asserts.
REQ-019 covered_count SHALL equal popcount(covered) at all times, registered together with covered, and SHALL saturate naturally at 2*SIG_WIDTH.
REQ-020 When clear=1: covered and covered_count SHALL be 0 next cycle, no raw edge SHALL be recorded, and valid SHALL be 0 next cycle (clear wins over simultaneous toggles).
REQ-021 When enable=0, valid SHALL be 0 next cycle and covered SHALL hold; prev SHALL still track sig, so re-enabling SHALL NOT produce a spurious edge.
REQ-022 Multiple bits toggling in the same cycle SHALL all be reported in the same valid word.

Reset
REQ-023 On reset_n low, asynchronously: valid=0, covered=0, covered_count=0, all_covered=0, prev=0, prev_valid=0.
REQ-024 Reset asserted mid-operation SHALL discard all state; the first post-reset sample SHALL NOT generate edges.

Structure
REQ-025 A shared package toggle_cov_pkg SHALL hold the RISE/FALL bit-offset constants (0/1) and a count-width function clog2(2*SIG_WIDTH+1).
REQ-026 One sub-module toggle_cov_cell SHALL implement per-signal-bit prev, rise/fall detection, sticky covered bits and valid registers; the top SHALL instantiate SIG_WIDTH cells and compute popcount.

Verification
REQ-027 Release reset with sig=18'h3FFFF held -> valid stays 0 for all cycles (first-sample suppression).
REQ-028 sig[0] 0->1 at edge N -> valid=36'h1 in cycle N+1 only, covered[0]=1, covered_count=1.
REQ-029 FIRST_ONLY=1, sig[0] toggles 0->1->0->1 -> valid bit0 once, bit1 once, then no further pulse; covered_count=2.
REQ-030 clear=1 in the same cycle sig[5] rises -> valid=0 next cycle, covered=0, covered_count=0; a later rise of sig[5] reports bit10.
REQ-031 All 18 bits rise then fall -> covered=36'hF_FFFF_FFFF, covered_count=36, all_covered=1.
REQ-032 enable=0 while sig[3] toggles, then enable=1 with sig steady -> no valid pulse, covered unchanged.
